// File: rtl/sbox_scheduler.sv
// Shares one masked S-box between SubBytes (state) and SubWord (key) jobs.
// It latches requests, issues one byte per cycle, and routes each result back to its owner via a tag pipe.
module sbox_scheduler #(
  parameter int SBOX_LAT = 6,
  parameter int N_STATE  = 16,
  parameter int N_KEY    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ss_start,
  input  logic        ks_start,
  output logic        ss_busy,
  output logic        ks_busy,
  output logic        rd_sel,
  output logic [3:0]  rd_idx,
  input  logic [15:0] rd_data,
  output logic [15:0] sbox_inp,
  output logic        prng_en,
  input  logic [15:0] sbox_out,
  output logic        wr_en,
  output logic        wr_sel,
  output logic [3:0]  wr_idx,
  output logic [15:0] wr_data,
  output logic        ss_done,
  output logic        ks_done
);

  typedef enum logic [1:0] {IDLE, ISSUE_S, ISSUE_K} state_t;

  typedef struct packed {
    logic       v;
    logic       sel;
    logic [3:0] idx;
    logic       last;
  } tag_t;

  localparam logic [3:0] LAST_S = 4'(N_STATE - 1);
  localparam logic [3:0] LAST_K = 4'(N_KEY - 1);

  state_t     state, state_nxt;
  logic       ss_pend, ks_pend;
  logic       ss_iss, ks_iss;
  logic [3:0] cnt;
  logic       ss_want, ks_want;
  logic       issuing, last_issue;
  tag_t       tag_push, tag_out;
  tag_t       tag_pipe [SBOX_LAT];
  logic       any_tag_v;

  // The start pulse is folded in directly so the first issue follows the request by one cycle.
  assign ks_want    = (ks_pend | ks_start) & ~ks_iss;
  assign ss_want    = (ss_pend | ss_start) & ~ss_iss;
  assign issuing    = (state == ISSUE_S) | (state == ISSUE_K);
  assign last_issue = ((state == ISSUE_K) & (cnt == LAST_K)) |
                      ((state == ISSUE_S) & (cnt == LAST_S));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ks_want)      state_nxt = ISSUE_K;
        else if (ss_want) state_nxt = ISSUE_S;
      end
      ISSUE_K: if (cnt == LAST_K) state_nxt = ss_want ? ISSUE_S : IDLE;
      ISSUE_S: if (cnt == LAST_S) state_nxt = ks_want ? ISSUE_K : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_sel   = (state == ISSUE_K);
    rd_idx   = issuing ? cnt : '0;
    sbox_inp = issuing ? rd_data : '0;
    tag_push = '0;
    if (issuing) begin
      tag_push.v    = 1'b1;
      tag_push.sel  = (state == ISSUE_K);
      tag_push.idx  = cnt;
      tag_push.last = last_issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      ss_pend <= 1'b0;
      ks_pend <= 1'b0;
      ss_iss  <= 1'b0;
      ks_iss  <= 1'b0;
    end else begin
      cnt <= (issuing && !last_issue) ? cnt + 4'd1 : '0;
      if (ss_done)       ss_pend <= 1'b0;
      else if (ss_start) ss_pend <= 1'b1;
      if (ks_done)       ks_pend <= 1'b0;
      else if (ks_start) ks_pend <= 1'b1;
      if (ss_done)                                    ss_iss <= 1'b0;
      else if (state == ISSUE_S && cnt == LAST_S)     ss_iss <= 1'b1;
      if (ks_done)                                    ks_iss <= 1'b0;
      else if (state == ISSUE_K && cnt == LAST_K)     ks_iss <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SBOX_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= tag_push;
      for (int unsigned i = 1; i < SBOX_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_comb begin
    any_tag_v = 1'b0;
    for (int unsigned i = 0; i < SBOX_LAT; i++) any_tag_v = any_tag_v | tag_pipe[i].v;
  end

  assign tag_out = tag_pipe[SBOX_LAT-1];
  assign prng_en = (state != IDLE) | any_tag_v;
  assign wr_en   = tag_out.v;
  assign wr_sel  = tag_out.sel;
  assign wr_idx  = tag_out.idx;
  assign wr_data = tag_out.v ? sbox_out : '0;
  assign ss_done = tag_out.v & ~tag_out.sel & tag_out.last;
  assign ks_done = tag_out.v &  tag_out.sel & tag_out.last;
  assign ss_busy = ss_pend;
  assign ks_busy = ks_pend;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler with a behavioural 6-stage masked AES S-box.
// Per-cycle expectations are derived from the issue and write windows of each job.
module tb_sbox_scheduler;

  logic        clk, rst, ss_start, ks_start;
  logic        ss_busy, ks_busy, rd_sel, prng_en, wr_en, wr_sel, ss_done, ks_done;
  logic [3:0]  rd_idx, wr_idx;
  logic [15:0] rd_data, sbox_inp, sbox_out, wr_data;

  logic [7:0]  st_orig [16];
  logic [7:0]  key_orig [16];
  logic [15:0] st_sh [16];
  logic [15:0] key_sh [16];
  logic [15:0] sp [6];

  int checks = 0;
  int failures = 0;

  sbox_scheduler #(.SBOX_LAT(6), .N_STATE(16), .N_KEY(4)) dut (
    .clk(clk), .rst(rst), .ss_start(ss_start), .ks_start(ks_start),
    .ss_busy(ss_busy), .ks_busy(ks_busy), .rd_sel(rd_sel), .rd_idx(rd_idx),
    .rd_data(rd_data), .sbox_inp(sbox_inp), .prng_en(prng_en), .sbox_out(sbox_out),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .ss_done(ss_done), .ks_done(ks_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign rd_data  = rd_sel ? key_sh[rd_idx] : st_sh[rd_idx];
  assign sbox_out = sp[5];

  always @(posedge clk) begin
    logic [7:0] r, y;
    r = 8'($urandom);
    y = sbox_f(sbox_inp[15:8] ^ sbox_inp[7:0]);
    for (int i = 5; i > 0; i--) sp[i] <= sp[i-1];
    sp[0] <= {y ^ r, r};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_shares();
    logic [7:0] r;
    for (int i = 0; i < 16; i++) begin
      r = 8'($urandom); st_sh[i]  = {st_orig[i] ^ r, r};
      r = 8'($urandom); key_sh[i] = {key_orig[i] ^ r, r};
    end
  endtask

  // k0/s0: first issue cycle of key/state job relative to the start cycle.
  task automatic run_case(input bit ss, input bit ks, input int k0, input int s0,
                          input int ncyc, input int rep);
    bit k_iss, s_iss, k_wr, s_wr;
    int first, lastwr;
    load_shares();
    first  = ks ? k0 : s0;
    lastwr = (ss ? s0 + 21 : 0) > (ks ? k0 + 9 : 0) ? s0 + 21 : k0 + 9;
    @(posedge clk); #1;
    ss_start = ss; ks_start = ks;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      k_iss = ks && c >= k0 && c < k0 + 4;
      s_iss = ss && c >= s0 && c < s0 + 16;
      k_wr  = ks && c >= k0 + 6 && c < k0 + 10;
      s_wr  = ss && c >= s0 + 6 && c < s0 + 22;
      if (k_iss) begin
        check("rd_sel_k", rd_sel, 1);
        check("rd_idx_k", rd_idx, c - k0);
        check("inp_k", sbox_inp[15:8] ^ sbox_inp[7:0], key_orig[c - k0]);
      end else if (s_iss) begin
        check("rd_sel_s", rd_sel, 0);
        check("rd_idx_s", rd_idx, c - s0);
        check("inp_s", sbox_inp[15:8] ^ sbox_inp[7:0], st_orig[c - s0]);
      end else begin
        check("inp_idle", sbox_inp, 0);
      end
      check("wr_en", wr_en, k_wr | s_wr);
      if (k_wr) begin
        check("wr_sel_k", wr_sel, 1);
        check("wr_idx_k", wr_idx, c - k0 - 6);
        check("wr_data_k", wr_data[15:8] ^ wr_data[7:0], sbox_f(key_orig[c - k0 - 6]));
      end else if (s_wr) begin
        check("wr_sel_s", wr_sel, 0);
        check("wr_idx_s", wr_idx, c - s0 - 6);
        check("wr_data_s", wr_data[15:8] ^ wr_data[7:0], sbox_f(st_orig[c - s0 - 6]));
      end else begin
        check("wr_data_idle", wr_data, 0);
      end
      check("ks_done", ks_done, ks && c == k0 + 9);
      check("ss_done", ss_done, ss && c == s0 + 21);
      check("ks_busy", ks_busy, ks && c >= 1 && c <= k0 + 9);
      check("ss_busy", ss_busy, ss && c >= 1 && c <= s0 + 21);
      check("prng_en", prng_en, c >= first && c <= lastwr);
      @(posedge clk); #1;
      ss_start = (rep > 0 && c + 1 == rep);
      ks_start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; ss_start = 1'b0; ks_start = 1'b0;
    for (int i = 0; i < 6; i++) sp[i] = '0;
    for (int i = 0; i < 16; i++) begin
      st_orig[i]  = 8'(i * 29 + 8'h53);
      key_orig[i] = 8'(i * 7 + 1);
    end
    st_orig[1] = 8'h00;
    key_orig[0] = 8'h53; key_orig[1] = 8'h00; key_orig[2] = 8'h01; key_orig[3] = 8'hff;
    load_shares();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_prng", prng_en, 0);
    check("rst_busy", {ss_busy, ks_busy}, 0);
    check("rst_done", {ss_done, ks_done}, 0);
    check("rst_rd", {rd_sel, rd_idx}, 0);
    check("rst_inp", sbox_inp, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_case(1'b0, 1'b1, 1, 0, 14, 0);
    run_case(1'b1, 1'b0, 0, 1, 26, 0);
    run_case(1'b1, 1'b1, 1, 5, 30, 0);
    // Second ss_start at cycle 5 while busy must not queue another job.
    run_case(1'b1, 1'b0, 0, 1, 34, 5);
    check("golden_53", sbox_f(key_orig[0]), 8'hed);

    load_shares();
    @(posedge clk); #1;
    ss_start = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (c >= 9) begin
        check("rst_mid_wr_en", wr_en, 0);
        check("rst_mid_prng", prng_en, 0);
        check("rst_mid_done", {ss_done, ks_done}, 0);
        check("rst_mid_busy", {ss_busy, ks_busy}, 0);
      end else if (c == 8) begin
        check("pre_rst_wr_en", wr_en, 1);
      end
      @(posedge clk); #1;
      ss_start = 1'b0;
      rst = (c + 1 == 9);
    end
    run_case(1'b0, 1'b1, 1, 0, 14, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
